// File: rtl/watch_pkg.sv
// Shared constants, state encoding and the fine/coarse step helper for the watch
// time controller.
package watch_pkg;

    localparam int FINE_W   = 3;
    localparam int COARSE_W = 4;
    localparam int HOUR_W   = 5;
    localparam int STATE_W  = 2;

    localparam logic [STATE_W-1:0] RUN      = 2'd0;
    localparam logic [STATE_W-1:0] SET_MIN  = 2'd1;
    localparam logic [STATE_W-1:0] SET_HOUR = 2'd2;

    localparam logic [FINE_W-1:0]   FINE_MAX    = 3'd4;
    localparam logic [COARSE_W-1:0] COARSE_MAX  = 4'd11;
    localparam logic [HOUR_W-1:0]   HOUR_MAX_12 = 5'd11;
    localparam logic [HOUR_W-1:0]   HOUR_MAX_24 = 5'd23;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = RUN,
        ST_SET_MIN  = SET_MIN,
        ST_SET_HOUR = SET_HOUR
    } state_t;

    typedef struct packed {
        logic                carry;
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
    } pair_t;

    // One-unit advance of a fine/coarse pair; carry flags the 59 -> 0 rollover.
    function automatic pair_t pair_inc(input logic [FINE_W-1:0]   fine,
                                       input logic [COARSE_W-1:0] coarse);
        pair_t r;
        r.carry  = 1'b0;
        r.fine   = fine + 1'b1;
        r.coarse = coarse;
        if (fine == FINE_MAX) begin
            r.fine = '0;
            if (coarse == COARSE_MAX) begin
                r.coarse = '0;
                r.carry  = 1'b1;
            end else begin
                r.coarse = coarse + 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/watch_time_ctrl_if.sv
// Time/status bundle produced by the watch controller and read by the display side.
interface watch_time_ctrl_if;
    import watch_pkg::*;

    logic                tick;
    logic [FINE_W-1:0]   sec_fine;
    logic [COARSE_W-1:0] sec_coarse;
    logic [FINE_W-1:0]   min_fine;
    logic [COARSE_W-1:0] min_coarse;
    logic [HOUR_W-1:0]   hour;
    logic                min_wrap;
    logic                hour_wrap;
    logic [STATE_W-1:0]  state;

    modport master (output tick, sec_fine, sec_coarse, min_fine, min_coarse,
                           hour, min_wrap, hour_wrap, state);
    modport slave  (input  tick, sec_fine, sec_coarse, min_fine, min_coarse,
                           hour, min_wrap, hour_wrap, state);
endinterface

// File: rtl/watch_btn_sync.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous button.
module watch_btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);
    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], btn};
            prev_reg <= sync_reg[1];
        end
    end

    assign rise = sync_reg[1] & ~prev_reg;
endmodule

// File: rtl/watch_time_ctrl.sv
// Watch timekeeping controller: 1 s prescaler, fine/coarse time fields, set-mode FSM.
// Build option WATCH_TIME_CTRL_24H_EN selects a 0-23 hour range (default 0-11).
module watch_time_ctrl
    import watch_pkg::*;
#(
    parameter int PRESCALE = 32768
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode_btn,
    input  logic                 inc_btn,
    watch_time_ctrl_if.master    tm
);
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

`ifdef WATCH_TIME_CTRL_24H_EN
    localparam int HOUR_REG_W = 5;
    localparam logic [HOUR_REG_W-1:0] HOUR_LAST = HOUR_REG_W'(HOUR_MAX_24);
`else
    // 12 h build keeps only four hour bits, so hour[4] reads as constant 0.
    localparam int HOUR_REG_W = 4;
    localparam logic [HOUR_REG_W-1:0] HOUR_LAST = HOUR_REG_W'(HOUR_MAX_12);
`endif

    logic [1:0] btn_raw;
    logic [1:0] btn_rise;
    logic       mode_rise;
    logic       inc_rise;

    assign btn_raw = {inc_btn, mode_btn};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        watch_btn_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw[gi]),
            .rise  (btn_rise[gi])
        );
    end

    assign mode_rise = btn_rise[0];
    assign inc_rise  = btn_rise[1];

    state_t                state_reg;
    logic [PS_W-1:0]       prescale_reg;
    logic [FINE_W-1:0]     sec_fine_reg;
    logic [COARSE_W-1:0]   sec_coarse_reg;
    logic [FINE_W-1:0]     min_fine_reg;
    logic [COARSE_W-1:0]   min_coarse_reg;
    logic [HOUR_REG_W-1:0] hour_reg;
    logic                  tick_reg;
    logic                  min_wrap_reg;
    logic                  hour_wrap_reg;

    pair_t                 sec_next;
    pair_t                 min_next;
    logic [HOUR_REG_W-1:0] hour_next;
    logic                  ps_wrap;

    always_comb begin
        sec_next  = pair_inc(sec_fine_reg, sec_coarse_reg);
        min_next  = pair_inc(min_fine_reg, min_coarse_reg);
        hour_next = (hour_reg == HOUR_LAST) ? '0 : hour_reg + 1'b1;
        ps_wrap   = (prescale_reg == PS_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_RUN;
            prescale_reg   <= '0;
            sec_fine_reg   <= '0;
            sec_coarse_reg <= '0;
            min_fine_reg   <= '0;
            min_coarse_reg <= '0;
            hour_reg       <= '0;
            tick_reg       <= 1'b0;
            min_wrap_reg   <= 1'b0;
            hour_wrap_reg  <= 1'b0;
        end else begin
            tick_reg      <= 1'b0;
            min_wrap_reg  <= 1'b0;
            hour_wrap_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (mode_rise) begin
                        state_reg      <= ST_SET_MIN;
                        prescale_reg   <= '0;
                        sec_fine_reg   <= '0;
                        sec_coarse_reg <= '0;
                    end else if (ps_wrap) begin
                        // Whole seconds->minutes->hours carry chain resolves on this one edge.
                        prescale_reg   <= '0;
                        tick_reg       <= 1'b1;
                        sec_fine_reg   <= sec_next.fine;
                        sec_coarse_reg <= sec_next.coarse;
                        if (sec_next.carry) begin
                            min_wrap_reg   <= 1'b1;
                            min_fine_reg   <= min_next.fine;
                            min_coarse_reg <= min_next.coarse;
                            if (min_next.carry) begin
                                hour_wrap_reg <= 1'b1;
                                hour_reg      <= hour_next;
                            end
                        end
                    end else begin
                        prescale_reg <= prescale_reg + 1'b1;
                    end
                end
                ST_SET_MIN: begin
                    prescale_reg <= '0;
                    if (mode_rise) begin
                        state_reg <= ST_SET_HOUR;
                    end else if (inc_rise) begin
                        min_fine_reg   <= min_next.fine;
                        min_coarse_reg <= min_next.coarse;
                    end
                end
                ST_SET_HOUR: begin
                    prescale_reg <= '0;
                    if (mode_rise) begin
                        state_reg <= ST_RUN;
                    end else if (inc_rise) begin
                        hour_reg <= hour_next;
                    end
                end
                default: begin
                    state_reg    <= ST_RUN;
                    prescale_reg <= '0;
                end
            endcase
        end
    end

    assign tm.tick       = tick_reg;
    assign tm.sec_fine   = sec_fine_reg;
    assign tm.sec_coarse = sec_coarse_reg;
    assign tm.min_fine   = min_fine_reg;
    assign tm.min_coarse = min_coarse_reg;
    assign tm.hour       = HOUR_W'(hour_reg);
    assign tm.min_wrap   = min_wrap_reg;
    assign tm.hour_wrap  = hour_wrap_reg;
    assign tm.state      = state_reg;
endmodule

// File: doc/watch_time_ctrl.md
# watch_time_ctrl

- Synchronous timekeeping controller for the homegrown watch.
- Turns the system clock into a 1 s tick and sequences the seconds, minutes and hours fields as fine/coarse pairs: fine counts 0–4, coarse counts 0–11 in 5-unit steps.
- Provides a button-driven set-mode state machine.
- Replaces ripple clocking between field registers: every field advances on `clk`, gated by enable strobes this block generates.

## Interface
- `PRESCALE`, default 32768: `clk` cycles per second; legal values are ≥ 2.
- `clk` input, 1: system clock; all state changes on its rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `mode_btn` input, 1: asynchronous mode button, active-high.
- `inc_btn` input, 1: asynchronous increment button, active-high.
- `tick` output, 1: one-cycle pulse once per second, in RUN only.
- `sec_fine` output, 3: seconds mod 5, range 0–4.
- `sec_coarse` output, 4: seconds div 5, range 0–11.
- `min_fine` output, 3: minutes mod 5, range 0–4.
- `min_coarse` output, 4: minutes div 5, range 0–11.
- `hour` output, 5: hours, range 0–11 (0–23 with the 24 h option, see Configuration).
- `min_wrap` output, 1: one-cycle pulse when seconds roll 59→0.
- `hour_wrap` output, 1: one-cycle pulse when minutes roll 59→0 in RUN.
- `state` output, 2: RUN=0, SET_MIN=1, SET_HOUR=2.

## Operation
- Both buttons pass through a two-flop synchronizer, then a rising-edge detector. One press produces one action, regardless of hold length.
- State machine:
  - RUN, mode press → SET_MIN.
  - SET_MIN, mode press → SET_HOUR.
  - SET_HOUR, mode press → RUN.
  - State value 3 is illegal and recovers to RUN on the next edge.
- RUN:
  - Prescaler counts 0..PRESCALE-1.
  - At PRESCALE-1 the prescaler wraps to 0, `tick` pulses, and seconds advance.
  - Seconds advance: `sec_fine` increments; at 4 it wraps to 0 and carries into `sec_coarse`.
  - `sec_coarse` at 11 with a fine carry wraps to 0, pulses `min_wrap`, and advances minutes with the same fine/coarse rule.
  - Minutes 59→0 pulses `hour_wrap` and increments `hour`. `hour` wraps 11→0 (23→0 with the 24 h option).
  - All carries resolve in one cycle: 11:59:59 → 00:00:00 on a single edge.
  - `inc_btn` is ignored in RUN.
- Entering SET_MIN: prescaler, `sec_fine` and `sec_coarse` clear to 0. The prescaler stays held at 0 through SET_MIN and SET_HOUR.
- SET_MIN, inc press: minutes +1 with fine→coarse carry; 59 wraps to 0. No hour carry, no `hour_wrap`.
- SET_HOUR, inc press: `hour` +1 with the usual wrap.
- Returning to RUN: prescaler starts from 0, so the first `tick` comes PRESCALE cycles after the state shows RUN.
- Simultaneous mode and inc edges in the same cycle: the mode transition wins and the inc is dropped.
- `reset` asserted mid-operation: all registers clear immediately, without waiting for `clk`.

## Timing
- Reset values:
  - all time fields 0;
  - `tick`, `min_wrap`, `hour_wrap` 0;
  - `state` RUN;
  - prescaler 0;
  - synchronizer and edge flops 0.
- Button latency: an input rising before edge N produces its action on edge N+2. The result is visible after edge N+2.
- `tick`, `min_wrap` and `hour_wrap` are registered and assert in the same cycle the updated field values appear.
- In RUN after reset release, the first `tick` is high for exactly one cycle, PRESCALE cycles later. Every later `tick` follows the previous one by exactly PRESCALE cycles.
- No output depends combinationally on an input.

## Configuration
- `WATCH_TIME_CTRL_24H_EN`
- Defined: `hour` range is 0–23, wraps 23→0.
- Undefined: `hour` range is 0–11, wraps 11→0; bit 4 of `hour` is tied 0.
- Port widths are identical in both builds.

## Structure
- Shared package `watch_pkg` holds:
  - the state encoding localparams (RUN, SET_MIN, SET_HOUR);
  - field limits: FINE_MAX=4, COARSE_MAX=11, HOUR_MAX_12=11, HOUR_MAX_24=23;
  - the field width constants.
- One sub-module, `watch_btn_sync`:
  - two-flop synchronizer plus rising-edge detector, with async active-low reset;
  - instantiated twice, once per button.
- Prescaler width is `$clog2(PRESCALE)`.

## Test plan
- Reset and run: PRESCALE=4; release `reset`, run 240 cycles (60 s) → `tick` pulses 60 times, 4 cycles apart; one `min_wrap` pulse; final fields are sec 0/0, min_fine=1, min_coarse=0.
- Full rollover: force time to 11:59:59, issue one `tick` → next cycle shows 00:00:00, with `min_wrap` and `hour_wrap` both high for 1 cycle. With `WATCH_TIME_CTRL_24H_EN`, preset 23:59:59 and expect the same result.
- Set minutes: press mode once (`state`=1, seconds cleared), press inc 62 times → minutes read 2 (fine=2, coarse=0), `hour` unchanged, no `hour_wrap`, no `tick`.
- Set hours: from SET_MIN press mode (`state`=2), press inc 13 times at hour 0 → `hour`=1 (12 h build); press mode → RUN, first `tick` exactly 4 cycles later.
- Button edges: hold inc high for 20 cycles in SET_HOUR → exactly one increment, applied 2 edges after the rise. Assert mode and inc in the same cycle → state advances and the field is unchanged.
- Async reset mid-run: assert `reset` between clock edges at time 05:37:42 → all outputs 0 before the next `clk` edge, `state`=RUN.
